syndrome_matcher: RTL and testbench

SYNDROME_MATCHER -- requirements
Module: syndrome_matcher

---
 rtl/syndrome_matcher.sv | 199 +++++++++++++++++++
 tb/tb_syndrome_matcher.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/syndrome_matcher.sv
// -----------------------------------------------------------------------------
// syndrome_matcher
//
// Collects a pass/fail syndrome (one bit per applied test vector) and looks it
// up in a fault dictionary, one dictionary entry per clock cycle.
//
// Flow: IDLE --start--> COLLECT --(syndrome complete)--> SCAN --> DONE --> IDLE
//       COLLECT goes straight to DONE when the completed syndrome is all zero.
//
// Optional feature macro: SYNDROME_MATCHER_FULL_SCAN_EN
//   defined   : SCAN visits every entry and match_count counts all matches.
//   undefined : SCAN stops in the cycle after the first match; match_count is
//               0 or 1.
//
// Ports
//   clk         in   single clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   start       in   begin a run (accepted only in IDLE)
//   resp_valid  in   qualifies resp_fail (accepted only in COLLECT)
//   resp_fail   in   1 = response to the current test vector mismatched
//   dict_we     in   dictionary write enable (accepted only in IDLE)
//   dict_addr   in   dictionary write index (IDX_W)
//   dict_wdata  in   dictionary syndrome for entry dict_addr (TEST_COUNT)
//   busy        out  high whenever the FSM is not IDLE
//   done        out  one-cycle pulse at the end of a run
//   pass_all    out  collected syndrome is all zero
//   match_found out  at least one entry equals the syndrome
//   match_idx   out  lowest matching entry index (IDX_W)
//   match_count out  number of matching entries (IDX_W+1)
//   syndrome    out  collected syndrome (TEST_COUNT)
// -----------------------------------------------------------------------------
module syndrome_matcher #(
  parameter int TEST_COUNT  = 66,
  parameter int FAULT_COUNT = 980,
  parameter int IDX_W       = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  resp_valid,
  input  logic                  resp_fail,
  input  logic                  dict_we,
  input  logic [IDX_W-1:0]      dict_addr,
  input  logic [TEST_COUNT-1:0] dict_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  pass_all,
  output logic                  match_found,
  output logic [IDX_W-1:0]      match_idx,
  output logic [IDX_W:0]        match_count,
  output logic [TEST_COUNT-1:0] syndrome
);

  // The counter runs one past the last test: cnt == TEST_COUNT marks a
  // complete syndrome and is evaluated in the cycle after the final response.
  localparam int               CNT_W       = $clog2(TEST_COUNT + 1);
  localparam logic [CNT_W-1:0] LP_CNT_FULL = CNT_W'(TEST_COUNT);
  localparam logic [CNT_W-1:0] LP_CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W:0]   LP_FC       = (IDX_W + 1)'(FAULT_COUNT);
  localparam logic [IDX_W-1:0] LP_IDX_LAST = IDX_W'(FAULT_COUNT - 1);
  localparam logic [IDX_W-1:0] LP_IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W:0]   LP_MC_ONE   = (IDX_W + 1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_SCAN    = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_scan_idx;
  logic [TEST_COUNT-1:0] r_syndrome;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_pass_all;
  logic                  r_match_found;
  logic [IDX_W-1:0]      r_match_idx;
  logic [IDX_W:0]        r_match_count;

  // Dictionary storage: deliberately has no reset so it survives rst_n.
  logic [TEST_COUNT-1:0] r_dict [FAULT_COUNT];

  logic w_dict_wr;
  logic w_hit;
  logic w_syn_zero;

  assign w_dict_wr  = dict_we && (r_state == ST_IDLE) && ({1'b0, dict_addr} < LP_FC);
  assign w_hit      = (r_dict[r_scan_idx] == r_syndrome);
  assign w_syn_zero = (r_syndrome == '0);

  // Dictionary write port, open only while idle.
  always_ff @(posedge clk) begin
    if (w_dict_wr) begin
      r_dict[dict_addr] <= dict_wdata;
    end
  end

  // Control FSM with all result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_scan_idx    <= '0;
      r_syndrome    <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_pass_all    <= 1'b0;
      r_match_found <= 1'b0;
      r_match_idx   <= '0;
      r_match_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state       <= ST_COLLECT;
            r_busy        <= 1'b1;
            r_cnt         <= '0;
            r_scan_idx    <= '0;
            r_syndrome    <= '0;
            r_pass_all    <= 1'b0;
            r_match_found <= 1'b0;
            r_match_idx   <= '0;
            r_match_count <= '0;
          end
        end
        ST_COLLECT: begin
          if (r_cnt == LP_CNT_FULL) begin
            // Syndrome complete: an all-zero syndrome needs no lookup.
            if (w_syn_zero) begin
              r_pass_all    <= 1'b1;
              r_match_found <= 1'b0;
              r_done        <= 1'b1;
              r_state       <= ST_DONE;
            end else begin
              r_scan_idx <= '0;
              r_state    <= ST_SCAN;
            end
          end else if (resp_valid) begin
            r_syndrome[r_cnt] <= resp_fail;
            r_cnt             <= r_cnt + LP_CNT_ONE;
          end
        end
        ST_SCAN: begin
`ifdef SYNDROME_MATCHER_FULL_SCAN_EN
          if (w_hit) begin
            r_match_count <= r_match_count + LP_MC_ONE;
            if (!r_match_found) begin
              r_match_found <= 1'b1;
              r_match_idx   <= r_scan_idx;
            end
          end
          if (r_scan_idx == LP_IDX_LAST) begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_scan_idx <= r_scan_idx + LP_IDX_ONE;
          end
`else
          // Early exit: the first hit ends the scan.
          if (w_hit) begin
            r_match_found <= 1'b1;
            r_match_idx   <= r_scan_idx;
            r_match_count <= LP_MC_ONE;
            r_done        <= 1'b1;
            r_state       <= ST_DONE;
          end else if (r_scan_idx == LP_IDX_LAST) begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_scan_idx <= r_scan_idx + LP_IDX_ONE;
          end
`endif
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign pass_all    = r_pass_all;
  assign match_found = r_match_found;
  assign match_idx   = r_match_idx;
  assign match_count = r_match_count;
  assign syndrome    = r_syndrome;

endmodule

// File: tb/tb_syndrome_matcher.sv
// -----------------------------------------------------------------------------
// tb_syndrome_matcher
//
// Self-checking bench for syndrome_matcher with default parameters.
// Expected results come from a vector table; each run pushes its expected
// record onto a scoreboard queue and pops it when done is observed.
// Expectations follow SYNDROME_MATCHER_FULL_SCAN_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_syndrome_matcher;

`ifdef SYNDROME_MATCHER_FULL_SCAN_EN
  localparam bit FULL = 1'b1;
`else
  localparam bit FULL = 1'b0;
`endif

  localparam int TC      = 66;
  localparam int FC      = 980;
  localparam int IW      = 10;
  localparam int LAT_LIM = 2000;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          resp_valid;
  logic          resp_fail;
  logic          dict_we;
  logic [IW-1:0] dict_addr;
  logic [TC-1:0] dict_wdata;
  logic          busy;
  logic          done;
  logic          pass_all;
  logic          match_found;
  logic [IW-1:0] match_idx;
  logic [IW:0]   match_count;
  logic [TC-1:0] syndrome;

  syndrome_matcher dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .resp_valid  (resp_valid),
    .resp_fail   (resp_fail),
    .dict_we     (dict_we),
    .dict_addr   (dict_addr),
    .dict_wdata  (dict_wdata),
    .busy        (busy),
    .done        (done),
    .pass_all    (pass_all),
    .match_found (match_found),
    .match_idx   (match_idx),
    .match_count (match_count),
    .syndrome    (syndrome)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [TC-1:0] syn;
    logic          pass;
    logic          found;
    logic [IW-1:0] idx;
    logic [IW:0]   cnt_f;
    logic [IW:0]   cnt_e;
    int            lat_f;
    int            lat_e;
  } vec_t;

  typedef struct {
    logic [TC-1:0] syn;
    logic          pass;
    logic          found;
    logic [IW-1:0] idx;
    logic [IW:0]   cnt;
    int            lat;
  } exp_t;

  vec_t vecs [7];
  exp_t sb_q [$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [TC-1:0] act, input logic [TC-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Dictionary contents used by every run: all-ones background plus a few
  // distinct entries at the low and high boundaries.
  function automatic logic [TC-1:0] dict_val(input int a);
    logic [TC-1:0] v;
    case (a)
      0:       v = 66'h4;
      3:       v = 66'h2A;
      5:       v = 66'h1;
      700:     v = 66'h2A;
      979:     v = 66'h3;
      default: v = '1;
    endcase
    return v;
  endfunction

  // mode 2: attempt a dictionary write to entry 10 while collecting.
  task automatic start_and_collect(input logic [TC-1:0] syn, input int mode);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < TC; i++) begin
      if (i % 9 == 4) begin
        resp_valid = 1'b0;
        resp_fail  = 1'b1;
        @(negedge clk);
      end
      if (mode == 2 && i == 10) begin
        dict_we    = 1'b1;
        dict_addr  = 10'd10;
        dict_wdata = 66'h55;
      end else begin
        dict_we = 1'b0;
      end
      resp_valid = 1'b1;
      resp_fail  = syn[i];
      @(negedge clk);
    end
    dict_we    = 1'b0;
    resp_valid = 1'b0;
    resp_fail  = 1'b0;
  endtask

  // mode 1: pulse start and resp_valid mid-SCAN, then poke resp_valid in IDLE.
  task automatic run_and_check(input exp_t e, input int mode);
    exp_t got;
    int   lat;
    sb_q.push_back(e);
    start_and_collect(e.syn, mode);
    lat = 1;
    while (!done && lat < LAT_LIM) begin
      if (mode == 1 && lat == 3) begin
        start      = 1'b1;
        resp_valid = 1'b1;
        resp_fail  = 1'b1;
      end else begin
        start      = 1'b0;
        resp_valid = 1'b0;
        resp_fail  = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start      = 1'b0;
    resp_valid = 1'b0;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty actual=0 expected=1");
    end else begin
      got = sb_q.pop_front();
      chk("done_seen", {65'd0, done}, 66'd1);
      chk("latency", TC'(lat), TC'(got.lat));
      chk("syndrome", syndrome, got.syn);
      chk("pass_all", {65'd0, pass_all}, {65'd0, got.pass});
      chk("match_found", {65'd0, match_found}, {65'd0, got.found});
      chk("match_idx", TC'(match_idx), TC'(got.idx));
      chk("match_count", TC'(match_count), TC'(got.cnt));
      @(negedge clk);
      chk("done_one_pulse", {65'd0, done}, 66'd0);
      chk("busy_after", {65'd0, busy}, 66'd0);
      if (mode == 1) begin
        resp_valid = 1'b1;
        resp_fail  = 1'b1;
        repeat (3) @(negedge clk);
        resp_valid = 1'b0;
        resp_fail  = 1'b0;
        chk("idle_resp_syndrome", syndrome, got.syn);
        chk("idle_resp_busy", {65'd0, busy}, 66'd0);
        chk("idle_resp_idx", TC'(match_idx), TC'(got.idx));
      end
    end
  endtask

  function automatic exp_t to_exp(input vec_t v);
    exp_t e;
    e.syn   = v.syn;
    e.pass  = v.pass;
    e.found = v.found;
    e.idx   = v.idx;
    e.cnt   = FULL ? v.cnt_f : v.cnt_e;
    e.lat   = FULL ? v.lat_f : v.lat_e;
    return e;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, {65'd0, busy}, 66'd0);
    chk({tag, "_done"}, {65'd0, done}, 66'd0);
    chk({tag, "_pass_all"}, {65'd0, pass_all}, 66'd0);
    chk({tag, "_match_found"}, {65'd0, match_found}, 66'd0);
    chk({tag, "_match_idx"}, TC'(match_idx), 66'd0);
    chk({tag, "_match_count"}, TC'(match_count), 66'd0);
    chk({tag, "_syndrome"}, syndrome, 66'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    int   lat;

    //        syn                        pass  found idx      cnt_f    cnt_e  lat_f lat_e
    vecs[0] = '{66'h1,                    1'b0, 1'b1, 10'd5,   11'd1,   11'd1, 982,  8};
    vecs[1] = '{66'h0,                    1'b1, 1'b0, 10'd0,   11'd0,   11'd0, 2,    2};
    vecs[2] = '{66'h2A,                   1'b0, 1'b1, 10'd3,   11'd2,   11'd1, 982,  6};
    vecs[3] = '{66'h4,                    1'b0, 1'b1, 10'd0,   11'd1,   11'd1, 982,  3};
    vecs[4] = '{66'h3,                    1'b0, 1'b1, 10'd979, 11'd1,   11'd1, 982,  982};
    vecs[5] = '{66'h2_0000_0000_0000_0000, 1'b0, 1'b0, 10'd0,  11'd0,   11'd0, 982,  982};
    vecs[6] = '{66'h3_FFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 10'd1,  11'd975, 11'd1, 982,  4};

    rst_n      = 1'b0;
    start      = 1'b0;
    resp_valid = 1'b0;
    resp_fail  = 1'b0;
    dict_we    = 1'b0;
    dict_addr  = '0;
    dict_wdata = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int a = 0; a < FC; a++) begin
      dict_we    = 1'b1;
      dict_addr  = IW'(a);
      dict_wdata = dict_val(a);
      @(negedge clk);
    end
    dict_we = 1'b0;

    for (int v = 0; v < 7; v++) begin
      run_and_check(to_exp(vecs[v]), 0);
    end

    // start and resp_valid during SCAN, resp_valid in IDLE: no effect.
    run_and_check(to_exp(vecs[0]), 1);

    // Reset while scanning entry 400.
    start_and_collect(66'h2_0000_0000_0000_0000, 0);
    lat = 1;
    while (lat < 402) begin
      @(negedge clk);
      lat++;
    end
    chk("busy_before_reset", {65'd0, busy}, 66'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midscan_reset");
    @(negedge clk);
    rst_n = 1'b1;
    resp_valid = 1'b1;
    resp_fail  = 1'b1;
    repeat (3) @(negedge clk);
    resp_valid = 1'b0;
    resp_fail  = 1'b0;
    chk("post_reset_resp_syndrome", syndrome, 66'd0);
    chk("post_reset_resp_busy", {65'd0, busy}, 66'd0);

    // Write to entry 10 during COLLECT must be dropped: no match for 66'h55.
    e.syn   = 66'h55;
    e.pass  = 1'b0;
    e.found = 1'b0;
    e.idx   = '0;
    e.cnt   = '0;
    e.lat   = 982;
    run_and_check(e, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
